// File: rtl/gpr_regfile_mp_pkg.sv
// Shared constants and types for the multi-port GPR file.
// The build option GPR_BYPASS_EN is consumed by gpr_regfile_mp.sv.
package gpr_regfile_mp_pkg;

  localparam int RF_NTHREADS = 4;
  localparam int RF_NREGS    = 64;
  localparam int RF_WID      = 32;
  localparam int RF_NRD      = 3;

  localparam int TidMSB = (RF_NTHREADS > 1) ? $clog2(RF_NTHREADS) - 1 : 0;
  localparam int RegMSB = $clog2(RF_NREGS) - 1;

  typedef logic [RF_WID-1:0] value_t;

  typedef struct packed {
    logic [TidMSB:0] tid;
    logic [RegMSB:0] rg;
  } regaddr_t;

endpackage

// File: rtl/gpr_regfile_mp_bank.sv
// One 1W1R byte-enable RAM copy with a registered, reset-able read port.
// Read-before-write on address collision; forwarding is done by the top.
module gpr_bank_sdp
  import gpr_regfile_mp_pkg::*;
#(
  parameter int AW  = 8,
  parameter int WID = RF_WID,
  localparam int NB    = WID / 8,
  localparam int DEPTH = 1 << AW
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [NB-1:0]  we,
  input  logic [AW-1:0]  waddr,
  input  logic [WID-1:0] wdata,
  input  logic [AW-1:0]  raddr,
  output logic [WID-1:0] rdata
);

  logic [WID-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int b = 0; b < NB; b++)
      if (we[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata <= '0;
    else        rdata <= mem[raddr];
  end

endmodule

// File: rtl/gpr_regfile_mp.sv
// Multi-read-port, multi-thread GPR file with a sequential clear engine.
// Define GPR_BYPASS_EN for write-first forwarding; default is read-before-write.
module gpr_regfile_mp
  import gpr_regfile_mp_pkg::*;
#(
  parameter int NTHREADS  = RF_NTHREADS,
  parameter int NREGS     = RF_NREGS,
  parameter int WID       = RF_WID,
  parameter int NRD       = RF_NRD,
  parameter bit REG0_ZERO = 1'b0,
  localparam int TW = (NTHREADS > 1) ? $clog2(NTHREADS) : 1,
  localparam int RW = $clog2(NREGS),
  localparam int AW = TW + RW,
  localparam int NB = WID / 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NB-1:0]           wr,
  input  logic [AW-1:0]           wa,
  input  logic [WID-1:0]          i,
  input  logic [NRD-1:0][AW-1:0]  ra,
  output logic [NRD-1:0][WID-1:0] o,
  input  logic                    clr_req,
  input  logic [TW-1:0]           clr_tid,
  output logic                    clr_ack,
  output logic                    rdy
);

  typedef enum logic [1:0] {CLR_ALL, IDLE, CLR_THR} clr_st_e;

  localparam logic [AW-1:0] LAST_ALL = AW'(NTHREADS * NREGS - 1);
  localparam logic [RW-1:0] LAST_REG = RW'(NREGS - 1);

  clr_st_e        st_q;
  logic [AW-1:0]  cnt_q;
  logic           rdy_q;
  logic           ack_q;

  // The counter's tid field doubles as the latched thread during CLR_THR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q  <= CLR_ALL;
      cnt_q <= '0;
      rdy_q <= 1'b0;
      ack_q <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      unique case (st_q)
        CLR_ALL: begin
          if (cnt_q == LAST_ALL) begin
            st_q  <= IDLE;
            rdy_q <= 1'b1;
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        IDLE: begin
          if (clr_req) begin
            st_q  <= CLR_THR;
            rdy_q <= 1'b0;
            ack_q <= 1'b1;
            cnt_q <= {clr_tid, {RW{1'b0}}};
          end
        end
        CLR_THR: begin
          if (cnt_q[RW-1:0] == LAST_REG) begin
            st_q  <= IDLE;
            rdy_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          st_q  <= CLR_ALL;
          rdy_q <= 1'b0;
          cnt_q <= '0;
        end
      endcase
    end
  end

  assign rdy     = rdy_q;
  assign clr_ack = ack_q;

  // rdy low means the clear engine owns the write bus.
  logic [NB-1:0]  we_eff;
  logic [AW-1:0]  wa_eff;
  logic [WID-1:0] wd_eff;

  assign we_eff = rdy_q ? wr : {NB{1'b1}};
  assign wa_eff = rdy_q ? wa : cnt_q;
  assign wd_eff = rdy_q ? i  : '0;

`ifdef GPR_BYPASS_EN
  logic [WID-1:0] wd_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wd_q <= '0;
    else        wd_q <= wd_eff;
  end
`endif

  for (genvar g = 0; g < NRD; g++) begin : g_port
    logic [WID-1:0] rdata;
    logic           z_q;

    gpr_bank_sdp #(.AW(AW), .WID(WID)) u_bank (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (we_eff),
      .waddr (wa_eff),
      .wdata (wd_eff),
      .raddr (ra[g]),
      .rdata (rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) z_q <= 1'b0;
      else        z_q <= REG0_ZERO && (ra[g][RW-1:0] == '0);
    end

`ifdef GPR_BYPASS_EN
    logic [NB-1:0]  hit_q;
    logic [WID-1:0] merged;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) hit_q <= '0;
      else        hit_q <= (wa_eff == ra[g]) ? we_eff : '0;
    end

    always_comb begin
      merged = rdata;
      for (int b = 0; b < NB; b++)
        if (hit_q[b]) merged[8*b +: 8] = wd_q[8*b +: 8];
    end

    assign o[g] = z_q ? '0 : merged;
`else
    assign o[g] = z_q ? '0 : rdata;
`endif
  end

endmodule

// File: tb/tb_gpr_regfile_mp.sv
// Directed bench for gpr_regfile_mp: default instance plus a REG0_ZERO=1 twin
// sharing the same stimulus; expectations follow GPR_BYPASS_EN when defined.
module tb_gpr_regfile_mp;
  import gpr_regfile_mp_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [3:0]       wr = '0;
  logic [7:0]       wa = '0;
  logic [31:0]      din = '0;
  logic [2:0][7:0]  ra = '0;
  logic [2:0][31:0] o, oz;
  logic             clr_req = 1'b0;
  logic [1:0]       clr_tid = '0;
  logic             clr_ack, rdy, ack_z, rdy_z;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  gpr_regfile_mp dut (
    .clk(clk), .rst_n(rst_n), .wr(wr), .wa(wa), .i(din), .ra(ra), .o(o),
    .clr_req(clr_req), .clr_tid(clr_tid), .clr_ack(clr_ack), .rdy(rdy)
  );

  gpr_regfile_mp #(.REG0_ZERO(1'b1)) dut_z (
    .clk(clk), .rst_n(rst_n), .wr(wr), .wa(wa), .i(din), .ra(ra), .o(oz),
    .clr_req(clr_req), .clr_tid(clr_tid), .clr_ack(ack_z), .rdy(rdy_z)
  );

  typedef struct {
    logic [3:0]  wr;
    logic [7:0]  wa;
    logic [31:0] din;
    logic [7:0]  ra;
    logic [31:0] exp;
    logic [31:0] expz;
  } vec_t;

  vec_t vt [12];

  function automatic logic [7:0] A(input int t, input int r);
    regaddr_t x;
    x.tid = t[1:0];
    x.rg  = r[5:0];
    return x;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic rd_chk(input string nm, input logic [7:0] a, input logic [31:0] exp,
                        input logic [31:0] expz);
    wr = '0;
    ra = {3{a}};
    tick();
    for (int p = 0; p < 3; p++) begin
      chk($sformatf("%s p%0d", nm, p), o[p], exp);
      chk($sformatf("%s z p%0d", nm, p), oz[p], expz);
    end
  endtask

  task automatic wait_rdy(output int cyc, output int acks);
    cyc = 0;
    acks = 0;
    while (!rdy && cyc < 5000) begin
      acks += int'(clr_ack);
      cyc++;
      tick();
    end
  endtask

  int cyc, acks;
  logic [31:0] e_byp;

  initial begin
    vt[0]  = '{4'hF, A(2,5),  32'hDEADBEEF, A(0,0),  32'h0,        32'h0};
    vt[1]  = '{4'h2, A(2,5),  32'h00001200, A(0,1),  32'h0,        32'h0};
    vt[2]  = '{4'h0, A(2,5),  32'hFFFFFFFF, A(2,5),  32'hDEAD12EF, 32'hDEAD12EF};
    vt[3]  = '{4'hF, A(0,0),  32'hFFFFFFFF, A(2,5),  32'hDEAD12EF, 32'hDEAD12EF};
    vt[4]  = '{4'hF, A(0,1),  32'hCAFEF00D, A(0,0),  32'hFFFFFFFF, 32'h0};
    vt[5]  = '{4'h0, A(0,0),  32'h0,        A(0,0),  32'hFFFFFFFF, 32'h0};
    vt[6]  = '{4'h0, A(0,0),  32'h0,        A(0,1),  32'hCAFEF00D, 32'hCAFEF00D};
    vt[7]  = '{4'h8, A(3,63), 32'hAB000000, A(0,1),  32'hCAFEF00D, 32'hCAFEF00D};
    vt[8]  = '{4'h1, A(3,63), 32'h000000CD, A(2,0),  32'h0,        32'h0};
    vt[9]  = '{4'h0, A(3,63), 32'h0,        A(3,63), 32'hAB0000CD, 32'hAB0000CD};
    vt[10] = '{4'h5, A(1,0),  32'h11223344, A(3,63), 32'hAB0000CD, 32'hAB0000CD};
    vt[11] = '{4'h0, A(1,0),  32'h0,        A(1,0),  32'h00220044, 32'h0};

    // Reset and power-on clear of all 256 entries.
    #2 rst_n = 1'b0;
    #1;
    chk("rst o0", o[0], 32'h0);
    chk("rst rdy", 32'(rdy), 32'h0);
    chk("rst ack", 32'(clr_ack), 32'h0);
    repeat (3) tick();
    rst_n = 1'b1;
    wait_rdy(cyc, acks);
    chk("clr_all cycles", 32'(cyc), 32'd256);
    chk("clr_all acks", 32'(acks), 32'd0);
    chk("clr_all rdy_z", 32'(rdy_z), 32'd1);
    for (int a = 0; a < 256; a++) begin
      ra = {3{a[7:0]}};
      tick();
      for (int p = 0; p < 3; p++) chk($sformatf("zero a%0d p%0d", a, p), o[p], 32'h0);
    end

    // Table: one write and one non-colliding read per cycle.
    for (int k = 0; k < 12; k++) begin
      wr = vt[k].wr; wa = vt[k].wa; din = vt[k].din; ra = {3{vt[k].ra}};
      tick();
      for (int p = 0; p < 3; p++) begin
        chk($sformatf("vec%0d p%0d", k, p), o[p], vt[k].exp);
        chk($sformatf("vec%0d z p%0d", k, p), oz[p], vt[k].expz);
      end
    end

    // Same-cycle write/read collision, full then partial lanes.
    wr = 4'hF; wa = A(1,7); din = 32'h0BADCAFE; ra = {3{A(0,1)}};
    tick();
    wr = 4'hF; wa = A(1,7); din = 32'h12345678; ra = {3{A(1,7)}};
    tick();
`ifdef GPR_BYPASS_EN
    e_byp = 32'h12345678;
`else
    e_byp = 32'h0BADCAFE;
`endif
    for (int p = 0; p < 3; p++) chk($sformatf("byp full p%0d", p), o[p], e_byp);
    wr = 4'h3; din = 32'h0000AAAA;
    tick();
`ifdef GPR_BYPASS_EN
    e_byp = 32'h1234AAAA;
`else
    e_byp = 32'h12345678;
`endif
    for (int p = 0; p < 3; p++) chk($sformatf("byp part p%0d", p), o[p], e_byp);
    rd_chk("after byp", A(1,7), 32'h1234AAAA, 32'h1234AAAA);

    // Fill thread 3, then clear it alone.
    ra = {3{A(0,0)}};
    for (int r = 0; r < 64; r++) begin
      wr = 4'hF; wa = A(3,r); din = 32'h30000000 | 32'(r);
      tick();
    end
    rd_chk("t3 filled", A(3,10), 32'h3000000A, 32'h3000000A);
    clr_req = 1'b1; clr_tid = 2'd3;
    tick();
    clr_req = 1'b0;
    wait_rdy(cyc, acks);
    chk("clr_thr cycles", 32'(cyc), 32'd64);
    chk("clr_thr acks", 32'(acks), 32'd1);
    for (int r = 0; r < 64; r++) rd_chk($sformatf("t3 r%0d", r), A(3,r), 32'h0, 32'h0);
    rd_chk("keep 2,5", A(2,5), 32'hDEAD12EF, 32'hDEAD12EF);
    rd_chk("keep 0,0", A(0,0), 32'hFFFFFFFF, 32'h0);
    rd_chk("keep 0,1", A(0,1), 32'hCAFEF00D, 32'hCAFEF00D);
    rd_chk("keep 1,0", A(1,0), 32'h00220044, 32'h0);
    rd_chk("keep 1,7", A(1,7), 32'h1234AAAA, 32'h1234AAAA);

    // Held request: one IDLE cycle between clears; writes during a clear drop.
    clr_req = 1'b1; clr_tid = 2'd1;
    tick();
    chk("b2b ack1", 32'(clr_ack), 32'd1);
    wait_rdy(cyc, acks);
    chk("b2b cyc1", 32'(cyc), 32'd64);
    chk("b2b acks1", 32'(acks), 32'd1);
    chk("b2b idle ack", 32'(clr_ack), 32'd0);
    tick();
    chk("b2b ack2", 32'(clr_ack), 32'd1);
    chk("b2b rdy2", 32'(rdy), 32'd0);
    clr_req = 1'b0;
    wr = 4'hF; wa = A(2,9); din = 32'h77777777;
    wait_rdy(cyc, acks);
    wr = '0;
    chk("b2b cyc2", 32'(cyc), 32'd64);
    rd_chk("dropped wr", A(2,9), 32'h0, 32'h0);
    rd_chk("t1 clr 1,7", A(1,7), 32'h0, 32'h0);
    rd_chk("t1 keep 2,5", A(2,5), 32'hDEAD12EF, 32'hDEAD12EF);

    // Reset 10 cycles into a thread clear restarts the full clear.
    ra = {3{A(2,5)}};
    clr_req = 1'b1; clr_tid = 2'd0;
    tick();
    clr_req = 1'b0;
    repeat (10) tick();
    chk("rd in clr", o[0], 32'hDEAD12EF);
    chk("rdy in clr", 32'(rdy), 32'd0);
    rst_n = 1'b0;
    #1;
    for (int p = 0; p < 3; p++) chk($sformatf("midrst o p%0d", p), o[p], 32'h0);
    chk("midrst rdy", 32'(rdy), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    wait_rdy(cyc, acks);
    chk("reclr cycles", 32'(cyc), 32'd256);
    rd_chk("reclr 2,5", A(2,5), 32'h0, 32'h0);
    rd_chk("reclr 0,1", A(0,1), 32'h0, 32'h0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/gpr_regfile_mp.md
Name: gpr_regfile_mp

Overview:
Multi-read-port, multi-thread general register file. It is the parametrised successor to the single-read-port GPR file. It provides NRD independent read ports, byte-lane writes, an optional write-to-read bypass, and a sequential clear engine. The clear engine zeroes the whole file after reset and zeroes a single thread's bank on request. It sits between the register-read stage and writeback in the rfPhoenix pipeline.

Parameters:
NTHREADS, 4, number of hardware thread banks (power of two, 1..16)
NREGS, 64, registers per thread (power of two)
WID, 32, register width in bits (multiple of 8)
NRD, 3, number of read ports (1..4)
REG0_ZERO, 1'b0, when 1 register 0 of every thread always reads as zero

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
wr  in  WID/8  byte-lane write enables
wa  in  TW+RW  write address {tid, reg}; TW=$clog2(NTHREADS), RW=$clog2(NREGS)
i  in  WID  write data
ra  in  NRD x (TW+RW)  read addresses, one per port
o  out  NRD x WID  read data, one per port
clr_req  in  1  request to clear one thread bank (level, held until acked)
clr_tid  in  TW  thread to clear
clr_ack  out  1  one-cycle pulse when a clear request is accepted
rdy  out  1  high when IDLE; external writes are accepted only when rdy=1

Behaviour:
- Storage is one 1W1R RAM per read port, all sharing a common write bus. Every write goes to all NRD copies.
- Read latency is 1 cycle: o[k] at cycle N+1 reflects ra[k] sampled at cycle N. The o registers are asynchronously reset to 0.
- Byte lane b (bits 8b+7:8b) is written only when wr[b]=1 and rdy=1. A write with wr=0 is a no-op.
- REG0_ZERO=1: any read whose reg field is 0 returns 0 regardless of stored data. Writes to register 0 are still stored.
- Effective write bus = external write when rdy=1, otherwise clear-engine write (all lanes, data 0).
- FSM states:
  - CLR_ALL: entered on reset. The counter walks addresses 0..NTHREADS*NREGS-1, one per cycle, writing 0. After the last address, go to IDLE.
  - IDLE: rdy=1. If clr_req=1, pulse clr_ack for one cycle, latch clr_tid, load counter={clr_tid,0}, go to CLR_THR.
  - CLR_THR: walks NREGS addresses of the latched thread, writing 0. After reg NREGS-1, go to IDLE.
- Clear duration: CLR_ALL takes exactly NTHREADS*NREGS cycles. CLR_THR takes exactly NREGS cycles. rdy is 0 for the whole walk.
- Reset values: rdy=0, clr_ack=0, o=0, counter=0, state=CLR_ALL.
- clr_req while in CLR_ALL or CLR_THR is not acked. The requester keeps it asserted and it is served on the first IDLE cycle.
- Back-to-back requests: after CLR_THR completes, the FSM spends one IDLE cycle with rdy=1 before the next ack.
- External writes presented while rdy=0 are dropped silently. The writer must qualify its writes with rdy.
- Reads are serviced in every state. They return memory contents, with clear writes visible per the bypass rule.
- rst_n asserted mid-clear restarts CLR_ALL from address 0. rst_n asserted mid-write does not guarantee that write is stored.

Optional Feature:
GPR_BYPASS_EN:
- Defined: write-first forwarding. If the effective write address equals ra[k] in cycle N, o[k] at N+1 takes the new data in each lane where the write enable is set, and the old data in the other lanes. REG0_ZERO still overrides the result.
- Undefined: read-before-write. o[k] at N+1 returns the pre-write contents on an address collision. The new data becomes visible from a read issued at N+1.

Decomposition:
- rfPhoenixPkg provides NTHREADS, NREGS, TidMSB, value_t (WID-bit register type), and a regaddr_t typedef {tid, reg}.
- Clear-FSM state enum (CLR_ALL, IDLE, CLR_THR) is local to the module.
- Sub-module gpr_bank_sdp: one 1W1R byte-enable block RAM with 1-cycle read latency (xpm_memory_sdpram wrapper), instantiated NRD times via generate.

Test Plan:
- Release rst_n with NTHREADS=4, NREGS=64 -> rdy stays 0 for exactly 256 cycles, then goes to 1; reading all addresses then returns 0.
- rdy=1, write wa={2,5}, i=32'hDEADBEEF, wr=4'hF, then wr=4'b0010 with i=32'h00001200 -> a read on port 2 returns 32'hDEAD12EF.
- Same-cycle write of 32'h12345678 to {1,7} with ra[0]={1,7} -> with GPR_BYPASS_EN, o[0] at N+1 = 32'h12345678; without it, o[0] = previous value.
- Fill thread 3 with nonzero data, pulse clr_req with clr_tid=3 -> clr_ack pulses once, rdy is 0 for 64 cycles, thread 3 reads 0 and threads 0..2 are unchanged.
- REG0_ZERO=1, write 32'hFFFFFFFF to {0,0} -> all ports read 0 at {0,0}; a write to {0,1} reads back normally.
- Assert rst_n low 10 cycles into CLR_THR -> o=0 and rdy=0 immediately; CLR_ALL restarts and completes in 256 cycles.
